// File: rtl/seg7_readback.sv
`default_nettype none
// ============================================================================
// Module   : seg7_readback
// Brief    : Debounced reader that decodes a two-digit 7-segment display back
//            to BCD/binary, flags illegal codes and counts accepted changes.
//            Optional: SEG7_BLANK_EN lets a blank tens digit (7'h00) read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_readback #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [6:0]       Tens,
    input  logic [6:0]       Ones,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic [6:0]       value,
    output logic             valid,
    output logic             invalid,
    output logic [CNT_W-1:0] update_cnt
);

    localparam int c_stab_w = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_stab_w-1:0] c_stab_max = c_stab_w'(STABLE_CYCLES);

`ifdef SEG7_BLANK_EN
    localparam logic c_blank_en = 1'b1;
`else
    localparam logic c_blank_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [13:0]         r_samp;
    logic [c_stab_w-1:0] r_stab;
    logic [c_stab_w-1:0] w_stab_next;
    logic                r_have;
    logic                w_diff;
    logic [4:0]          w_tens_dec;
    logic [4:0]          w_ones_dec;
    logic                w_legal;
    logic [6:0]          w_value;

    // Returns {legal, digit}; blank_ok admits an unlit digit as 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg, input logic blank_ok);
        logic [4:0] d;
        case (seg)
            7'h7E:   d = {1'b1, 4'd0};
            7'h30:   d = {1'b1, 4'd1};
            7'h6D:   d = {1'b1, 4'd2};
            7'h79:   d = {1'b1, 4'd3};
            7'h33:   d = {1'b1, 4'd4};
            7'h5B:   d = {1'b1, 4'd5};
            7'h5F:   d = {1'b1, 4'd6};
            7'h70:   d = {1'b1, 4'd7};
            7'h7F:   d = {1'b1, 4'd8};
            7'h7B:   d = {1'b1, 4'd9};
            7'h00:   d = blank_ok ? {1'b1, 4'd0} : 5'd0;
            default: d = 5'd0;
        endcase
        return d;
    endfunction

    assign w_diff      = ({Tens, Ones} != r_samp);
    assign w_stab_next = w_diff ? '0 :
                         (r_stab == c_stab_max) ? r_stab : r_stab + c_stab_w'(1);
    assign w_tens_dec  = seg_decode(r_samp[13:7], c_blank_en);
    assign w_ones_dec  = seg_decode(r_samp[6:0], 1'b0);
    assign w_legal     = w_tens_dec[4] & w_ones_dec[4];
    assign w_value     = 7'(w_tens_dec[3:0]) * 7'd10 + 7'(w_ones_dec[3:0]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = ST_SETTLE;
            ST_SETTLE: if (!w_diff && w_stab_next == c_stab_max) w_next = ST_ACCEPT;
            ST_ACCEPT: w_next = w_diff ? ST_SETTLE : ST_LOCKED;
            ST_LOCKED: if (w_diff) w_next = ST_SETTLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_samp     <= '0;
            r_stab     <= '0;
            r_have     <= 1'b0;
            bcd_tens   <= '0;
            bcd_ones   <= '0;
            value      <= '0;
            valid      <= 1'b0;
            invalid    <= 1'b0;
            update_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_samp  <= {Tens, Ones};
            r_stab  <= w_stab_next;
            valid   <= 1'b0;
            // ACCEPT judges the pattern that settled, even if the pins move now.
            if (r_state == ST_ACCEPT) begin
                if (!w_legal) begin
                    invalid <= 1'b1;
                end else begin
                    invalid <= 1'b0;
                    if (!r_have || w_value != value) begin
                        r_have     <= 1'b1;
                        bcd_tens   <= w_tens_dec[3:0];
                        bcd_ones   <= w_ones_dec[3:0];
                        value      <= w_value;
                        valid      <= 1'b1;
                        update_cnt <= update_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_readback
// Brief    : Directed self-checking bench for seg7_readback (default and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_readback;

    logic        clk = 1'b0;
    logic        Reset;
    logic [6:0]  Tens, Ones;
    logic [3:0]  bcd_tens, bcd_ones;
    logic [6:0]  value;
    logic        valid, invalid;
    logic [15:0] update_cnt;
    logic [3:0]  d2_bcd_tens, d2_bcd_ones;
    logic [6:0]  d2_value;
    logic        d2_valid, d2_invalid;
    logic [1:0]  d2_update_cnt;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;
    int vbase;

    always #5 clk = ~clk;

    seg7_readback #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .Reset(Reset), .Tens(Tens), .Ones(Ones),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .value(value),
        .valid(valid), .invalid(invalid), .update_cnt(update_cnt)
    );

    seg7_readback #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .Reset(Reset), .Tens(Tens), .Ones(Ones),
        .bcd_tens(d2_bcd_tens), .bcd_ones(d2_bcd_ones), .value(d2_value),
        .valid(d2_valid), .invalid(d2_invalid), .update_cnt(d2_update_cnt)
    );

    always @(negedge clk) if (valid === 1'b1) vcount++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0; Tens = 7'h7E; Ones = 7'h30;
        tick(5);
        checks++;
        if ({bcd_tens, bcd_ones, value, valid, invalid, update_cnt} !== 33'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {bcd_tens, bcd_ones, value, valid, invalid, update_cnt});
        end
        checks++;
        if ({d2_value, d2_valid, d2_invalid, d2_update_cnt} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs_cnt2 got=%h want=0", {d2_value, d2_valid, d2_invalid, d2_update_cnt});
        end
    endtask

    task automatic test_first_accept;
        vbase = vcount;
        Reset = 1'b1;
        tick(1);                      // edge E0 captures 7E/30
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL early_valid at E0+%0d got=%b want=0", i, valid);
            end
        end
        tick(1);                      // E0+5
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL latency_valid got=%b want=1", valid);
        end
        checks++;
        if ({bcd_tens, bcd_ones, value, invalid} !== {4'd0, 4'd1, 7'd1, 1'b0}) begin
            failures++;
            $display("FAIL first_value got=%0d/%0d/%0d inv=%b want=0/1/1 inv=0", bcd_tens, bcd_ones, value, invalid);
        end
        checks++;
        if (update_cnt !== 16'd1) begin
            failures++;
            $display("FAIL first_cnt got=%0d want=1", update_cnt);
        end
        tick(6);
        checks++;
        if (vcount - vbase !== 1) begin
            failures++;
            $display("FAIL first_pulse_count got=%0d want=1", vcount - vbase);
        end
    endtask

    task automatic test_glitch;
        vbase = vcount;
        Ones = 7'h6D;
        tick(2);
        Ones = 7'h30;
        tick(10);
        checks++;
        if (vcount - vbase !== 0 || value !== 7'd1 || update_cnt !== 16'd1) begin
            failures++;
            $display("FAIL glitch got pulses=%0d value=%0d cnt=%0d want 0/1/1", vcount - vbase, value, update_cnt);
        end
    endtask

    task automatic test_new_value;
        vbase = vcount;
        Tens = 7'h79; Ones = 7'h7B;
        tick(8);
        checks++;
        if (vcount - vbase !== 1 || value !== 7'd39 || bcd_tens !== 4'd3 || bcd_ones !== 4'd9 || update_cnt !== 16'd2) begin
            failures++;
            $display("FAIL value39 got pulses=%0d value=%0d bcd=%0d/%0d cnt=%0d want 1/39/3/9/2",
                     vcount - vbase, value, bcd_tens, bcd_ones, update_cnt);
        end
    endtask

    task automatic test_illegal;
        vbase = vcount;
        Ones = 7'h01;
        tick(8);
        checks++;
        if (invalid !== 1'b1 || value !== 7'd39 || vcount - vbase !== 0) begin
            failures++;
            $display("FAIL illegal got inv=%b value=%0d pulses=%0d want 1/39/0", invalid, value, vcount - vbase);
        end
        Tens = 7'h6D; Ones = 7'h7E;
        tick(8);
        checks++;
        if (invalid !== 1'b0 || value !== 7'd20 || vcount - vbase !== 1 || update_cnt !== 16'd3) begin
            failures++;
            $display("FAIL recover20 got inv=%b value=%0d pulses=%0d cnt=%0d want 0/20/1/3",
                     invalid, value, vcount - vbase, update_cnt);
        end
    endtask

    task automatic test_blank;
        vbase = vcount;
        Tens = 7'h00; Ones = 7'h5B;
        tick(8);
        checks++;
`ifdef SEG7_BLANK_EN
        if (invalid !== 1'b0 || value !== 7'd5 || vcount - vbase !== 1 || update_cnt !== 16'd4) begin
            failures++;
            $display("FAIL blank got inv=%b value=%0d pulses=%0d cnt=%0d want 0/5/1/4",
                     invalid, value, vcount - vbase, update_cnt);
        end
`else
        if (invalid !== 1'b1 || value !== 7'd20 || vcount - vbase !== 0 || update_cnt !== 16'd3) begin
            failures++;
            $display("FAIL blank got inv=%b value=%0d pulses=%0d cnt=%0d want 1/20/0/3",
                     invalid, value, vcount - vbase, update_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back;
        Tens = 7'h30; Ones = 7'h30;   // 11
        tick(1);                      // E0
        tick(4);                      // E0+4: FSM sits in ACCEPT
        Tens = 7'h6D; Ones = 7'h6D;   // 22 arrives during ACCEPT
        tick(1);
        checks++;
        if (valid !== 1'b1 || value !== 7'd11) begin
            failures++;
            $display("FAIL accept_cycle_change got valid=%b value=%0d want 1/11", valid, value);
        end
        tick(5);
        checks++;
        if (valid !== 1'b1 || value !== 7'd22) begin
            failures++;
            $display("FAIL after_change got valid=%b value=%0d want 1/22", valid, value);
        end
    endtask

    task automatic test_async_reset;
        Tens = 7'h7B; Ones = 7'h7B;
        tick(2);                      // mid-SETTLE
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({bcd_tens, bcd_ones, value, valid, invalid, update_cnt} !== 33'd0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", {bcd_tens, bcd_ones, value, valid, invalid, update_cnt});
        end
        tick(3);
    endtask

    task automatic test_wrap;
        logic [13:0] pats [4];
        pats[0] = {7'h30, 7'h6D};     // 12
        pats[1] = {7'h79, 7'h33};     // 34
        pats[2] = {7'h5B, 7'h5F};     // 56
        pats[3] = {7'h70, 7'h7F};     // 78
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {Tens, Ones} = pats[i];
            tick(8);
            if (i == 2) begin
                checks++;
                if (d2_update_cnt !== 2'd3) begin
                    failures++;
                    $display("FAIL cnt2_three got=%0d want=3", d2_update_cnt);
                end
            end
        end
        checks++;
        if (d2_update_cnt !== 2'd0 || update_cnt !== 16'd4 || value !== 7'd78) begin
            failures++;
            $display("FAIL wrap got cnt2=%0d cnt=%0d value=%0d want 0/4/78", d2_update_cnt, update_cnt, value);
        end
    endtask

    initial begin
        test_reset;
        test_first_accept;
        test_glitch;
        test_new_value;
        test_illegal;
        test_blank;
        test_back_to_back;
        test_async_reset;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
